// File: rtl/icache_refill_ctrl_if.sv
// Fetch/cache/memory bundle of the icache refill controller.
// The controller takes the master side; the CPU/cache/memory environment takes the slave side.
interface icache_refill_ctrl_if #(
    parameter int ADDR_W = 20,
    parameter int DATA_W = 32,
    parameter int CNT_W  = 16
) ();
    logic              pc_valid;
    logic [ADDR_W-1:0] pc;
    logic              pc_ready;
    logic              flush;
    logic              instr_valid;
    logic [DATA_W-1:0] instr;
    logic              instr_err;
    logic              read_en;
    logic [ADDR_W-1:0] read_addr;
    logic              cache_miss;
    logic [DATA_W-1:0] cache_rdata;
    logic              fetch;
    logic [ADDR_W-1:0] write_addr;
    logic [DATA_W-1:0] write_data;
    logic              mem_req;
    logic [ADDR_W-1:0] mem_addr;
    logic              mem_ack;
    logic [DATA_W-1:0] mem_rdata;
    logic [CNT_W-1:0]  miss_count;

    modport master (
        input  pc_valid, pc, flush, cache_miss, cache_rdata, mem_ack, mem_rdata,
        output pc_ready, instr_valid, instr, instr_err, read_en, read_addr,
               fetch, write_addr, write_data, mem_req, mem_addr, miss_count
    );

    modport slave (
        output pc_valid, pc, flush, cache_miss, cache_rdata, mem_ack, mem_rdata,
        input  pc_ready, instr_valid, instr, instr_err, read_en, read_addr,
               fetch, write_addr, write_data, mem_req, mem_addr, miss_count
    );
endinterface

// File: rtl/icache_refill_ctrl.sv
// Icache refill controller: one outstanding fetch, cache lookup, memory refill on miss,
// request timeout, flush abort and a saturating miss counter.
module icache_refill_ctrl #(
    parameter int ADDR_W         = 20,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255,
    parameter int CNT_W          = 16
) (
    input  logic                  i_clk_cpu,
    input  logic                  i_rst,
    icache_refill_ctrl_if.master  io_bus
);
    typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_CHECK, S_MEM_REQ, S_FILL} state_t;

    localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [TO_W-1:0] TO_LAST = TO_W'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);

    state_t            r_state;
    logic [ADDR_W-1:0] r_addr;
    logic              r_read_en;
    logic              r_mem_req;
    logic              r_fetch;
    logic [DATA_W-1:0] r_wdata;
    logic              r_instr_valid;
    logic [DATA_W-1:0] r_instr;
    logic              r_instr_err;
    logic [CNT_W-1:0]  r_miss_cnt;
    logic [TO_W-1:0]   r_to;
    logic              r_abort;

    logic w_abort;
    logic w_expire;
    logic w_cnt_max;

    // A flush in the same cycle as the ack/expiry already cancels the CPU response.
    assign w_abort   = r_abort | io_bus.flush;
    assign w_expire  = (TIMEOUT_CYCLES != 0) && (r_to == TO_LAST);
    assign w_cnt_max = &r_miss_cnt;

    always_ff @(posedge i_clk_cpu or posedge i_rst) begin
        if (i_rst) begin
            r_state       <= S_IDLE;
            r_addr        <= '0;
            r_read_en     <= 1'b0;
            r_mem_req     <= 1'b0;
            r_fetch       <= 1'b0;
            r_wdata       <= '0;
            r_instr_valid <= 1'b0;
            r_instr       <= '0;
            r_instr_err   <= 1'b0;
            r_miss_cnt    <= '0;
            r_to          <= '0;
            r_abort       <= 1'b0;
        end else begin
            r_read_en     <= 1'b0;
            r_fetch       <= 1'b0;
            r_instr_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_abort <= 1'b0;
                    if (io_bus.pc_valid && !io_bus.flush) begin
                        r_addr    <= io_bus.pc & ~ADDR_W'(3);
                        r_read_en <= 1'b1;
                        r_state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    r_state <= io_bus.flush ? S_IDLE : S_CHECK;
                end
                S_CHECK: begin
                    if (io_bus.cache_miss && !w_cnt_max)
                        r_miss_cnt <= r_miss_cnt + CNT_W'(1);
                    if (io_bus.flush) begin
                        r_state <= S_IDLE;
                    end else if (io_bus.cache_miss) begin
                        r_mem_req <= 1'b1;
                        r_to      <= '0;
                        r_state   <= S_MEM_REQ;
                    end else begin
                        r_instr_valid <= 1'b1;
                        r_instr       <= io_bus.cache_rdata;
                        r_instr_err   <= 1'b0;
                        r_state       <= S_IDLE;
                    end
                end
                S_MEM_REQ: begin
                    if (io_bus.flush)
                        r_abort <= 1'b1;
                    if (io_bus.mem_ack) begin
                        r_mem_req <= 1'b0;
                        r_fetch   <= 1'b1;
                        r_wdata   <= io_bus.mem_rdata;
                        if (!w_abort) begin
                            r_instr_valid <= 1'b1;
                            r_instr       <= io_bus.mem_rdata;
                            r_instr_err   <= 1'b0;
                        end
                        r_state <= S_FILL;
                    end else if (w_expire) begin
                        r_mem_req <= 1'b0;
                        if (!w_abort) begin
                            r_instr_valid <= 1'b1;
                            r_instr       <= '0;
                            r_instr_err   <= 1'b1;
                        end
                        r_state <= S_IDLE;
                    end else begin
                        r_to <= r_to + TO_W'(1);
                    end
                end
                S_FILL: begin
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Gated by reset so nothing is offered while the controller is held in reset.
    assign io_bus.pc_ready    = (r_state == S_IDLE) & ~io_bus.flush & ~i_rst;
    assign io_bus.instr_valid = r_instr_valid;
    assign io_bus.instr       = r_instr;
    assign io_bus.instr_err   = r_instr_err;
    assign io_bus.read_en     = r_read_en;
    assign io_bus.read_addr   = r_addr;
    assign io_bus.fetch       = r_fetch;
    assign io_bus.write_addr  = r_addr;
    assign io_bus.write_data  = r_wdata;
    assign io_bus.mem_req     = r_mem_req;
    assign io_bus.mem_addr    = r_addr;
    assign io_bus.miss_count  = r_miss_cnt;
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: table vectors, directed reset/flush sequences and a random
// phase checked against a transaction-level reference model.
module tb_icache_refill_ctrl;
    localparam int AW = 20;
    localparam int DW = 32;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    icache_refill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(16)) ifa ();
    icache_refill_ctrl_if #(.ADDR_W(AW), .DATA_W(DW), .CNT_W(2))  ifb ();

    // Second instance (short timeout, 2-bit counter) sees the same stimulus.
    assign ifb.pc_valid    = ifa.pc_valid;
    assign ifb.pc          = ifa.pc;
    assign ifb.flush       = ifa.flush;
    assign ifb.cache_miss  = ifa.cache_miss;
    assign ifb.cache_rdata = ifa.cache_rdata;
    assign ifb.mem_ack     = ifa.mem_ack;
    assign ifb.mem_rdata   = ifa.mem_rdata;

    icache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(255), .CNT_W(16)) dut_a (
        .i_clk_cpu(clk), .i_rst(rst), .io_bus(ifa));
    icache_refill_ctrl #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(4), .CNT_W(2)) dut_b (
        .i_clk_cpu(clk), .i_rst(rst), .io_bus(ifb));

    int nchk = 0;
    int nerr = 0;

    typedef struct {
        int          nvalid;
        logic [31:0] instr;
        bit          err;
        int          fetches;
        int          req;
        logic [31:0] mc;
    } exp_t;

    typedef struct {
        bit          rst_before;
        bit          sel;
        logic [19:0] pc;
        bit          miss;
        logic [31:0] rdata;
        int          d;
        logic [31:0] mr;
        int          fl;
        exp_t        e;
    } vec_t;

    typedef struct {
        bit          acc_ok;
        bit          rd_ok;
        logic [31:0] rd_addr;
        int          nvalid;
        logic [31:0] instr;
        bit          err;
        int          fetches;
        logic [31:0] waddr;
        logic [31:0] wdata;
        int          req;
        bit          addr_bad;
        bit          overlap;
        bit          hung;
    } obs_t;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h required %0h", nm, got, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        ifa.pc_valid = 0; ifa.pc = '0; ifa.flush = 0; ifa.cache_miss = 0;
        ifa.cache_rdata = '0; ifa.mem_ack = 0; ifa.mem_rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    // fl: 0 none, 1 flush during LOOKUP, 2 flush in first mem_req cycle.
    // d: mem_req cycle in which ack is given (0 = never).
    task automatic run_fetch(input bit sel, input logic [19:0] pc, input bit miss,
                             input logic [31:0] rdata, input int d, input logic [31:0] mr,
                             input int fl, output obs_t o);
        logic [31:0] ea;
        logic req, fe, re, iv, ie, rdy;
        logic [31:0] ma, wa, wd, ins;
        bit done;
        ea = {12'b0, pc & 20'hFFFFC};
        o = '{default: 0};
        done = 0;
        @(negedge clk);
        o.acc_ok = sel ? ifb.pc_ready : ifa.pc_ready;
        ifa.pc_valid = 1'b1;
        ifa.pc = pc;
        @(negedge clk);
        ifa.pc_valid = 1'b0;
        o.rd_ok   = sel ? ifb.read_en : ifa.read_en;
        o.rd_addr = sel ? 32'(ifb.read_addr) : 32'(ifa.read_addr);
        ifa.cache_miss  = miss;
        ifa.cache_rdata = rdata;
        ifa.flush       = (fl == 1);
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            req = sel ? ifb.mem_req : ifa.mem_req;
            ma  = sel ? 32'(ifb.mem_addr) : 32'(ifa.mem_addr);
            fe  = sel ? ifb.fetch : ifa.fetch;
            wa  = sel ? 32'(ifb.write_addr) : 32'(ifa.write_addr);
            wd  = sel ? ifb.write_data : ifa.write_data;
            re  = sel ? ifb.read_en : ifa.read_en;
            iv  = sel ? ifb.instr_valid : ifa.instr_valid;
            ins = sel ? ifb.instr : ifa.instr;
            ie  = sel ? ifb.instr_err : ifa.instr_err;
            rdy = sel ? ifb.pc_ready : ifa.pc_ready;
            if (req) begin
                o.req++;
                if (ma !== ea) o.addr_bad = 1;
            end
            if (fe) begin o.fetches++; o.waddr = wa; o.wdata = wd; end
            if (fe && re) o.overlap = 1;
            if (iv) begin o.nvalid++; o.instr = ins; o.err = ie; end
            ifa.flush = 1'b0;
            if (rdy) begin done = 1; break; end
            ifa.mem_ack   = req && (d != 0) && (o.req == d);
            ifa.mem_rdata = ifa.mem_ack ? mr : $urandom;
            if (fl == 2 && req && o.req == 1) ifa.flush = 1'b1;
        end
        ifa.mem_ack = 1'b0;
        ifa.flush = 1'b0;
        ifa.cache_miss = 1'b0;
        if (!done) o.hung = 1;
    endtask

    task automatic compare(input string t, input bit sel, input logic [19:0] pc,
                           input logic [31:0] mr, input obs_t o, input exp_t e);
        logic [31:0] ea;
        ea = {12'b0, pc & 20'hFFFFC};
        check({t, ".no_hang"}, 32'(o.hung), 0);
        check({t, ".pc_ready"}, 32'(o.acc_ok), 1);
        check({t, ".read_en"}, 32'(o.rd_ok), 1);
        check({t, ".read_addr"}, o.rd_addr, ea);
        check({t, ".instr_valid_cnt"}, o.nvalid, e.nvalid);
        if (e.nvalid != 0) begin
            check({t, ".instr"}, o.instr, e.instr);
            check({t, ".instr_err"}, 32'(o.err), 32'(e.err));
        end
        check({t, ".fetch_cnt"}, o.fetches, e.fetches);
        if (e.fetches != 0) begin
            check({t, ".write_addr"}, o.waddr, ea);
            check({t, ".write_data"}, o.wdata, mr);
        end
        check({t, ".mem_req_cycles"}, o.req, e.req);
        check({t, ".mem_addr_stable"}, 32'(o.addr_bad), 0);
        check({t, ".fetch_read_overlap"}, 32'(o.overlap), 0);
        check({t, ".miss_count"}, sel ? 32'(ifb.miss_count) : 32'(ifa.miss_count), e.mc);
    endtask

    // Reference: outcome of one fetch from the behavioural rules, given timeout T.
    function automatic exp_t model(input bit miss, input logic [31:0] rdata, input int d,
                                   input logic [31:0] mr, input int fl, input int T);
        exp_t e;
        e = '{default: 0};
        if (fl == 1) return e;
        if (!miss) begin
            e.nvalid = 1;
            e.instr = rdata;
            return e;
        end
        if (d != 0 && (T == 0 || d <= T)) begin
            e.req = d;
            e.fetches = 1;
            e.instr = mr;
        end else begin
            e.req = T;
            e.err = 1;
            e.instr = 0;
        end
        e.nvalid = (fl == 2) ? 0 : 1;
        return e;
    endfunction

    function automatic vec_t mkv(input bit rb, input bit sel, input logic [19:0] pc,
                                 input bit miss, input logic [31:0] rdata, input int d,
                                 input logic [31:0] mr, input int fl, input int nv,
                                 input logic [31:0] ins, input bit err, input int fe,
                                 input int req, input logic [31:0] mc);
        vec_t v;
        v.rst_before = rb; v.sel = sel; v.pc = pc; v.miss = miss; v.rdata = rdata;
        v.d = d; v.mr = mr; v.fl = fl;
        v.e.nvalid = nv; v.e.instr = ins; v.e.err = err; v.e.fetches = fe;
        v.e.req = req; v.e.mc = mc;
        return v;
    endfunction

    vec_t tbl[11];

    initial begin
        obs_t o;
        exp_t e;
        logic [31:0] mc;
        tbl[0]  = mkv(1, 0, 20'h00104, 0, 32'h00500093, 0, 32'h0,        0, 1, 32'h00500093, 0, 0, 0, 0);
        tbl[1]  = mkv(0, 0, 20'h3F008, 1, 32'h0,        5, 32'hDEADBEEF, 0, 1, 32'hDEADBEEF, 0, 1, 5, 1);
        tbl[2]  = mkv(0, 0, 20'h12347, 1, 32'h0,        1, 32'hCAFEF00D, 0, 1, 32'hCAFEF00D, 0, 1, 1, 2);
        tbl[3]  = mkv(0, 0, 20'h00200, 1, 32'h0,        3, 32'h11112222, 2, 0, 32'h0,        0, 1, 3, 3);
        tbl[4]  = mkv(0, 0, 20'h00300, 1, 32'h0,        0, 32'h0,        1, 0, 32'h0,        0, 0, 0, 3);
        tbl[5]  = mkv(0, 0, 20'hFFFFF, 0, 32'h0,        0, 32'h0,        0, 1, 32'h0,        0, 0, 0, 3);
        tbl[6]  = mkv(1, 1, 20'h00040, 1, 32'h0,        0, 32'h0,        0, 1, 32'h0,        1, 0, 4, 1);
        tbl[7]  = mkv(0, 1, 20'h00044, 1, 32'h0,        4, 32'h0BADF00D, 0, 1, 32'h0BADF00D, 0, 1, 4, 2);
        tbl[8]  = mkv(0, 1, 20'h00048, 1, 32'h0,        2, 32'h01234567, 0, 1, 32'h01234567, 0, 1, 2, 3);
        tbl[9]  = mkv(0, 1, 20'h0004C, 1, 32'h0,        1, 32'h89ABCDEF, 0, 1, 32'h89ABCDEF, 0, 1, 1, 3);
        tbl[10] = mkv(0, 1, 20'h00050, 1, 32'h0,        5, 32'h55555555, 0, 1, 32'h0,        1, 0, 4, 3);

        do_reset();
        @(negedge clk);
        check("reset.pc_ready", 32'(ifa.pc_ready), 1);
        check("reset.miss_count", 32'(ifa.miss_count), 0);
        check("reset.instr_valid", 32'(ifa.instr_valid), 0);

        for (int i = 0; i < 11; i++) begin
            if (tbl[i].rst_before) do_reset();
            run_fetch(tbl[i].sel, tbl[i].pc, tbl[i].miss, tbl[i].rdata, tbl[i].d,
                      tbl[i].mr, tbl[i].fl, o);
            compare($sformatf("vec%0d", i), tbl[i].sel, tbl[i].pc, tbl[i].mr, o, tbl[i].e);
        end

        // Reset in the middle of a memory request.
        do_reset();
        @(negedge clk);
        ifa.pc_valid = 1; ifa.pc = 20'h00ABC;
        @(negedge clk);
        ifa.pc_valid = 0; ifa.cache_miss = 1;
        for (int c = 0; c < 10 && !ifa.mem_req; c++) @(negedge clk);
        repeat (2) @(negedge clk);
        check("rstmid.mem_req_before", 32'(ifa.mem_req), 1);
        #2 rst = 1'b1;
        #1;
        check("rstmid.mem_req", 32'(ifa.mem_req), 0);
        check("rstmid.fetch", 32'(ifa.fetch), 0);
        check("rstmid.instr_valid", 32'(ifa.instr_valid), 0);
        check("rstmid.miss_count", 32'(ifa.miss_count), 0);
        check("rstmid.pc_ready", 32'(ifa.pc_ready), 0);
        ifa.cache_miss = 0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rstmid.idle", 32'(ifa.pc_ready), 1);
        check("rstmid.no_fetch", 32'(ifa.fetch | ifa.instr_valid | ifa.mem_req), 0);

        // Flush together with pc_valid in IDLE: nothing accepted.
        ifa.flush = 1; ifa.pc_valid = 1; ifa.pc = 20'h00777;
        #1;
        check("flushidle.pc_ready", 32'(ifa.pc_ready), 0);
        @(negedge clk);
        ifa.flush = 0; ifa.pc_valid = 0;
        check("flushidle.read_en", 32'(ifa.read_en), 0);
        @(negedge clk);
        check("flushidle.read_en2", 32'(ifa.read_en), 0);
        check("flushidle.pc_ready2", 32'(ifa.pc_ready), 1);

        // Random phase on the long-timeout instance.
        do_reset();
        mc = 0;
        for (int i = 0; i < 40; i++) begin
            logic [19:0] pc;
            logic [31:0] rd, mr;
            bit miss;
            int d, fl;
            pc   = 20'($urandom);
            rd   = $urandom;
            mr   = $urandom;
            miss = ($urandom_range(0, 2) != 0);
            d    = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 8));
            fl   = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, 2)) : 0;
            e = model(miss, rd, d, mr, fl, 255);
            if (miss && fl != 1 && mc != 32'hFFFF) mc = mc + 1;
            e.mc = mc;
            run_fetch(0, pc, miss, rd, d, mr, fl, o);
            compare($sformatf("rnd%0d", i), 0, pc, mr, o, e);
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
